control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: one-clock states T0..T7 drive Datapath strobes decoded from IR_op.
// Optional CU_MEM_WAIT_EN: T1, ld T6 and st T7 hold while Mem_ready is low.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [OPW-1:0] IR_op,
  input  logic           CON_FF,
  input  logic           Stop,
  input  logic           Mem_ready,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           Cout,
  output logic           BAout,
  output logic           Rout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Rin,
  output logic           CONin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [1:0]     ALUsel,
  output logic           Run,
  output logic           Illegal
);

  typedef logic [OPW-1:0] op_t;
  localparam op_t OP_LD   = op_t'(5'b00000);
  localparam op_t OP_LDI  = op_t'(5'b00001);
  localparam op_t OP_ST   = op_t'(5'b00010);
  localparam op_t OP_ADD  = op_t'(5'b00011);
  localparam op_t OP_SUB  = op_t'(5'b00100);
  localparam op_t OP_AND  = op_t'(5'b00101);
  localparam op_t OP_OR   = op_t'(5'b00110);
  localparam op_t OP_ADDI = op_t'(5'b01100);
  localparam op_t OP_BR   = op_t'(5'b10010);
  localparam op_t OP_JR   = op_t'(5'b10011);
  localparam op_t OP_NOP  = op_t'(5'b11000);
  localparam op_t OP_HALT = op_t'(5'b11001);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_BR, C_JR, C_NOP, C_HALT, C_BAD
  } cls_t;

  state_t     state_q, state_n;
  cls_t       cls;
  logic [1:0] alu_op;
  logic       illegal_q;
  logic       set_illegal;
  logic       last;
  logic       mem_hold;
  logic       wait_en;

`ifdef CU_MEM_WAIT_EN
  assign wait_en = !Mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = Mem_ready;
  assign wait_en = 1'b0;
`endif

  always_comb begin
    cls    = C_BAD;
    alu_op = 2'b00;
    case (IR_op)
      OP_LD:   cls = C_LD;
      OP_LDI:  cls = C_LDI;
      OP_ST:   cls = C_ST;
      OP_ADD:  begin cls = C_ALU; alu_op = 2'b00; end
      OP_SUB:  begin cls = C_ALU; alu_op = 2'b01; end
      OP_AND:  begin cls = C_ALU; alu_op = 2'b10; end
      OP_OR:   begin cls = C_ALU; alu_op = 2'b11; end
      OP_ADDI: cls = C_ADDI;
      OP_BR:   cls = C_BR;
      OP_JR:   cls = C_JR;
      OP_NOP:  cls = C_NOP;
      OP_HALT: cls = C_HALT;
      default: cls = C_BAD;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign Illegal = illegal_q;

  always_comb begin
    state_n     = state_q;
    set_illegal = 1'b0;
    last        = 1'b0;
    mem_hold    = 1'b0;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Rin = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    ALUsel = 2'b00;
    Run = (state_q != S_RST) && (state_q != S_HALT);

    case (state_q)
      S_RST: state_n = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_n = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        mem_hold = wait_en;
        state_n = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        // nop is recognised from the opcode the datapath presents while IR loads.
        if (cls == C_NOP) last = 1'b1;
        else              state_n = S_T3;
      end
      S_T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_n = S_T4; end
          C_ALU, C_ADDI:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_n = S_T4; end
          C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_n = S_T4; end
          C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last = 1'b1; end
          C_NOP:             last = 1'b1;
          C_HALT:            state_n = S_HALT;
          default: begin
            state_n     = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_T4: begin
        case (cls)
          C_LD, C_LDI, C_ST, C_ADDI: begin Cout = 1'b1; Zin = 1'b1; state_n = S_T5; end
          C_ALU: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUsel = alu_op;
            state_n = S_T5;
          end
          C_BR:    begin PCout = 1'b1; Yin = 1'b1; state_n = S_T5; end
          default: last = 1'b1;
        endcase
      end
      S_T5: begin
        case (cls)
          C_LD, C_ST:           begin Zlowout = 1'b1; MARin = 1'b1; state_n = S_T6; end
          C_LDI, C_ALU, C_ADDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
          C_BR:                 begin Cout = 1'b1; Zin = 1'b1; state_n = S_T6; end
          default:              last = 1'b1;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD: begin Read = 1'b1; MDRin = 1'b1; mem_hold = wait_en; state_n = S_T7; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_n = S_T7; end
          C_BR: begin
            Zlowout = CON_FF; PCin = CON_FF;
            last = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
          C_ST:    begin Write = 1'b1; mem_hold = wait_en; last = 1'b1; end
          default: last = 1'b1;
        endcase
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_RST;
    endcase

    if (last) state_n = Stop ? S_HALT : S_T0;
    // A memory stall freezes the state, so the boundary Stop sample waits too.
    if (mem_hold) state_n = state_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table-driven latency checks, hand-written corner sequences, randomized program vs reference model.
module tb_control_sequencer;

`ifdef CU_MEM_WAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  localparam logic [24:0] PCOUT   = 25'h1 << 0;
  localparam logic [24:0] ZLOWOUT = 25'h1 << 1;
  localparam logic [24:0] MDROUT  = 25'h1 << 3;
  localparam logic [24:0] COUT    = 25'h1 << 4;
  localparam logic [24:0] BAOUT   = 25'h1 << 5;
  localparam logic [24:0] ROUT    = 25'h1 << 6;
  localparam logic [24:0] MARIN   = 25'h1 << 7;
  localparam logic [24:0] ZIN     = 25'h1 << 8;
  localparam logic [24:0] PCIN    = 25'h1 << 9;
  localparam logic [24:0] MDRIN   = 25'h1 << 10;
  localparam logic [24:0] IRIN    = 25'h1 << 11;
  localparam logic [24:0] YIN     = 25'h1 << 12;
  localparam logic [24:0] RIN     = 25'h1 << 13;
  localparam logic [24:0] CONIN   = 25'h1 << 14;
  localparam logic [24:0] GRA     = 25'h1 << 15;
  localparam logic [24:0] GRB     = 25'h1 << 16;
  localparam logic [24:0] GRC     = 25'h1 << 17;
  localparam logic [24:0] INCPC   = 25'h1 << 18;
  localparam logic [24:0] READ    = 25'h1 << 19;
  localparam logic [24:0] WRITE   = 25'h1 << 20;
  localparam logic [24:0] RUN     = 25'h1 << 23;
  localparam logic [24:0] ILL     = 25'h1 << 24;
  localparam logic [24:0] T0W     = RUN | PCOUT | MARIN | INCPC | ZIN;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic [4:0] IR_op = 5'd0;
  logic       CON_FF = 1'b0;
  logic       Stop = 1'b0;
  logic       Mem_ready = 1'b1;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run, Illegal;
  logic [1:0] ALUsel;
  logic [24:0] obs;

  control_sequencer #(.OPW(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .IR_op(IR_op), .CON_FF(CON_FF), .Stop(Stop),
    .Mem_ready(Mem_ready), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .Cout(Cout), .BAout(BAout), .Rout(Rout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
    .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
    .Write(Write), .ALUsel(ALUsel), .Run(Run), .Illegal(Illegal)
  );

  assign obs = {Illegal, Run, ALUsel, Write, Read, IncPC, Grc, Grb, Gra, CONin, Rin, Yin,
                IRin, MDRin, PCin, Zin, MARin, Rout, BAout, Cout, MDRout, Zhighout,
                Zlowout, PCout};

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_pass = 0;
  logic [24:0] exp_q[$];
  bit seq_halts;
  bit seq_illegal;

  typedef struct {
    logic [4:0]  op;
    logic        con;
    int          len;
    logic [24:0] last;
  } vec_t;
  vec_t tbl[12];
  logic [4:0] pool [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected per-cycle strobe words of one instruction, straight from its micro-step list.
  task automatic build_seq(input logic [4:0] op, input logic con);
    logic [1:0] a;
    exp_q.delete();
    seq_halts = 1'b0;
    seq_illegal = 1'b0;
    exp_q.push_back(T0W);
    exp_q.push_back(RUN | ZLOWOUT | PCIN | READ | MDRIN);
    exp_q.push_back(RUN | MDROUT | IRIN);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        exp_q.push_back(RUN | GRB | BAOUT | YIN);
        exp_q.push_back(RUN | COUT | ZIN);
        if (op == 5'b00001) exp_q.push_back(RUN | ZLOWOUT | GRA | RIN);
        else begin
          exp_q.push_back(RUN | ZLOWOUT | MARIN);
          if (op == 5'b00000) begin
            exp_q.push_back(RUN | READ | MDRIN);
            exp_q.push_back(RUN | MDROUT | GRA | RIN);
          end else begin
            exp_q.push_back(RUN | GRA | ROUT | MDRIN);
            exp_q.push_back(RUN | WRITE);
          end
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        a = 2'(op - 5'd3);
        exp_q.push_back(RUN | GRB | ROUT | YIN);
        exp_q.push_back(RUN | GRC | ROUT | ZIN | 25'({a, 21'd0}));
        exp_q.push_back(RUN | ZLOWOUT | GRA | RIN);
      end
      5'b01100: begin
        exp_q.push_back(RUN | GRB | ROUT | YIN);
        exp_q.push_back(RUN | COUT | ZIN);
        exp_q.push_back(RUN | ZLOWOUT | GRA | RIN);
      end
      5'b10010: begin
        exp_q.push_back(RUN | GRA | ROUT | CONIN);
        exp_q.push_back(RUN | PCOUT | YIN);
        exp_q.push_back(RUN | COUT | ZIN);
        exp_q.push_back(con ? (RUN | ZLOWOUT | PCIN) : RUN);
      end
      5'b10011: exp_q.push_back(RUN | GRA | ROUT | PCIN);
      5'b11000: ;
      5'b11001: begin exp_q.push_back(RUN); seq_halts = 1'b1; end
      default: begin exp_q.push_back(RUN); seq_halts = 1'b1; seq_illegal = 1'b1; end
    endcase
  endtask

  function automatic bit is_wait(input logic [4:0] op, input int k);
    return (k == 1) || (op == 5'b00000 && k == 6) || (op == 5'b00010 && k == 7);
  endfunction

  // Runs one instruction from its T0 cycle; abort_at >= 0 drops Resetn in that step.
  task automatic run_instr(input logic [4:0] op, input logic con, input int stop_from,
                           input int abort_at, input string tag);
    int k;
    int stalls;
    build_seq(op, con);
    k = 0;
    stalls = 0;
    while (k < exp_q.size()) begin
      @(negedge Clock);
      check($sformatf("%s op=%b step=%0d", tag, op, k), 32'(obs), 32'(exp_q[k]));
      if (k == abort_at) begin
        Resetn = 1'b0;
        #1 check($sformatf("%s abort outputs", tag), 32'(obs), 32'd0);
        return;
      end
      if (k == 0) begin IR_op = op; CON_FF = con; end
      Stop = (stop_from >= 0) && (k >= stop_from);
      Mem_ready = (stalls >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      if (MEMWAIT && is_wait(op, k) && !Mem_ready) stalls++;
      else begin k++; stalls = 0; end
    end
  endtask

  task automatic check_halt(input int n, input logic ill, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      check($sformatf("%s cycle %0d", tag, i), 32'(obs), ill ? 32'(ILL) : 32'd0);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Stop = 1'b0; IR_op = 5'd0; CON_FF = 1'b0; Mem_ready = 1'b1;
    #1 check("reset async outputs", 32'(obs), 32'd0);
    repeat (2) @(negedge Clock);
    check("reset held outputs", 32'(obs), 32'd0);
    Resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [24:0] lastw;
    logic [4:0] rop;

    tbl[0]  = '{5'b00000, 1'b0, 8, RUN | MDROUT | GRA | RIN};
    tbl[1]  = '{5'b00001, 1'b0, 6, RUN | ZLOWOUT | GRA | RIN};
    tbl[2]  = '{5'b00010, 1'b0, 8, RUN | WRITE};
    tbl[3]  = '{5'b00011, 1'b0, 6, RUN | ZLOWOUT | GRA | RIN};
    tbl[4]  = '{5'b00100, 1'b1, 6, RUN | ZLOWOUT | GRA | RIN};
    tbl[5]  = '{5'b00101, 1'b0, 6, RUN | ZLOWOUT | GRA | RIN};
    tbl[6]  = '{5'b00110, 1'b1, 6, RUN | ZLOWOUT | GRA | RIN};
    tbl[7]  = '{5'b01100, 1'b0, 6, RUN | ZLOWOUT | GRA | RIN};
    tbl[8]  = '{5'b10010, 1'b0, 7, RUN};
    tbl[9]  = '{5'b10010, 1'b1, 7, RUN | ZLOWOUT | PCIN};
    tbl[10] = '{5'b10011, 1'b0, 4, RUN | GRA | ROUT | PCIN};
    tbl[11] = '{5'b11000, 1'b0, 3, RUN | MDROUT | IRIN};
    pool[0] = 5'b00000; pool[1] = 5'b00001; pool[2] = 5'b00010; pool[3] = 5'b00011;
    pool[4] = 5'b00100; pool[5] = 5'b00101; pool[6] = 5'b00110; pool[7] = 5'b01100;
    pool[8] = 5'b10010; pool[9] = 5'b10011; pool[10] = 5'b11000;

    #2;
    do_reset();
    run_instr(5'b00000, 1'b0, -1, -1, "ld");
    run_instr(5'b00011, 1'b0, -1, -1, "add");
    run_instr(5'b00100, 1'b0, -1, -1, "sub");
    run_instr(5'b00101, 1'b0, -1, -1, "and");
    run_instr(5'b00110, 1'b0, -1, -1, "or");
    run_instr(5'b10010, 1'b0, -1, -1, "br_nt");
    run_instr(5'b10010, 1'b1, -1, -1, "br_t");

    // Latency table: count cycles from one T0 to the next, check the final strobe word.
    @(negedge Clock);
    check("table sync T0", 32'(obs), 32'(T0W));
    Mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      IR_op = tbl[i].op;
      CON_FF = tbl[i].con;
      cnt = 1;
      lastw = obs;
      for (int c = 0; c < 20; c++) begin
        @(negedge Clock);
        if (obs == T0W) break;
        cnt++;
        lastw = obs;
      end
      check($sformatf("table[%0d] op=%b cycles", i, tbl[i].op), 32'(cnt), 32'(tbl[i].len));
      check($sformatf("table[%0d] op=%b last step", i, tbl[i].op), 32'(lastw), 32'(tbl[i].last));
    end

    do_reset();
    for (int n = 0; n < 40; n++) begin
      rop = pool[$urandom_range(0, 10)];
      run_instr(rop, 1'($urandom_range(0, 1)), -1, -1, "rand");
    end

    run_instr(5'b00000, 1'b0, 4, -1, "ld_stop");
    check_halt(20, 1'b0, "stop halt");

    do_reset();
    run_instr(5'b11001, 1'b0, -1, -1, "halt");
    check_halt(5, 1'b0, "halt op");

    do_reset();
    run_instr(5'b11111, 1'b0, -1, -1, "illegal");
    check_halt(20, 1'b1, "illegal halt");
    Resetn = 1'b0;
    #1 check("illegal cleared by reset", 32'(obs), 32'd0);

    do_reset();
    run_instr(5'b00010, 1'b1, -1, 6, "st_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
